cmult_stream: RTL and testbench
===============================

CMULT_STREAM -- requirements
Module: cmult_stream

Interface
REQ-001 Parameter AWIDTH, default 16, signed width of operand A components.
REQ-002 Parameter BWIDTH, default 18, signed width of operand B components.
REQ-003 Parameter OWIDTH, default 16, signed width of output components.
REQ-004 Parameter SHIFT, default 17, right-shift applied to the full product before output (0..AWIDTH+BWIDTH).
REQ-005 Parameter UWIDTH, default 8, width of sideband user tag.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 in_valid  in  1  input sample valid.
REQ-009 in_ready  out  1  block accepts input this cycle.
REQ-010 ar, ai  in  AWIDTH each  signed A real/imag.
REQ-011 br, bi  in  BWIDTH each  signed B real/imag.
REQ-012 conj_b  in  1  per-sample mode: 1 = multiply by conjugate of B.
REQ-013 in_user  in  UWIDTH  tag carried with sample.
REQ-014 out_valid  out  1  output sample valid.
REQ-015 out_ready  in  1  downstream accepts output.
REQ-016 pr, pi  out  OWIDTH each  signed rounded/saturated product.
REQ-017 ovf  out  1  saturation occurred on pr or pi of this output sample.
REQ-018 out_user  out  UWIDTH  tag of this output sample.

Function
REQ-019 Full-precision result SHALL be: conj_b=0 -> pr=ar*br-ai*bi, pi=ar*bi+ai*br; conj_b=1 -> pr=ar*br+ai*bi, pi=ai*br-ar*bi; held in AWIDTH+BWIDTH+1 bits, never wrapping, including all-minimum-value operands.
REQ-020 Implementation SHALL use three real multipliers per sample (shared common term), not four.
REQ-021 Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
REQ-022 Global advance ce = !out_valid | out_ready; in_ready SHALL equal ce; whole pipeline, valid bits, conj_b and user tags SHALL hold when ce=0.
REQ-023 Latency SHALL be exactly 6 advancing cycles from input transfer to out_valid for that sample; bubbles SHALL propagate as invalid slots and not be collapsed.
REQ-024 Samples SHALL exit in order with their own conj_b result and in_user.
REQ-025 Rounding: for SHIFT>0 add 2^(SHIFT-1) in AWIDTH+BWIDTH+2 bits, then arithmetic shift right by SHIFT (round half toward +inf); SHIFT=0 passes unchanged.
REQ-026 Saturation: shifted value outside OWIDTH signed range SHALL clamp to max (2^(OWIDTH-1)-1) or min (-2^(OWIDTH-1)); ovf=1 if either component clamped.
REQ-027 Invalid slots SHALL not assert ovf; pr/pi/out_user contents are don't-care while out_valid=0.
REQ-028 Full throughput: one sample per cycle when out_ready held high.

Reset
REQ-029 rst_n low SHALL immediately clear all valid bits: out_valid=0, ovf=0, pr=pi=0, out_user=0; in_ready=1 while reset is asserted.
REQ-030 Samples in flight at reset SHALL be discarded; no stale output after rst_n release.
REQ-031 Data-path registers other than outputs need no reset.

Structure
REQ-032 Shared package cmult_pkg SHALL hold the latency constant (CMULT_LAT=6) and a function computing full product width AWIDTH+BWIDTH+1.
REQ-033 Round/saturate stage SHALL be a sub-module round_sat (params IWIDTH, OWIDTH, SHIFT; one register stage, ovf output).

Verification (AWIDTH=16, BWIDTH=18, UWIDTH=8)
REQ-034 OWIDTH=16, SHIFT=17; ar=16384, ai=0, br=65536, bi=0, user=0x5A -> 6 cycles later pr=8192, pi=0, ovf=0, out_user=0x5A.
REQ-035 OWIDTH=35, SHIFT=0; a=(1000,2000), b=(3000,4000): conj_b=0 -> (-5000000, 10000000); conj_b=1 next cycle -> (11000000, 2000000) on consecutive cycles.
REQ-036 OWIDTH=16, SHIFT=17; ar=ai=-32768, br=-131072, bi=131071, conj_b=0 -> pr=32767, pi=0, ovf=1.
REQ-037 Stream 20 random samples with out_ready low for cycles 8-10 -> in_ready low those cycles, outputs held stable, all 20 match golden model in order, none lost or duplicated.
REQ-038 Pulse rst_n low with 4 samples in flight -> out_valid=0 asynchronously, no output within 10 cycles of release without new input, next input emerges after exactly 6 cycles.

Source files
------------

// File: rtl/cmult_pkg.sv
// Shared constants and helpers for the streaming complex multiplier.
// Latency: n/a (package). Backpressure: n/a.
// Contents: CMULT_LAT pipeline depth and the full-precision product width helper.
package cmult_pkg;

  // Number of advancing cycles from input transfer to out_valid.
  localparam int CMULT_LAT = 6;

  // Width that holds either full complex-product component without wrapping.
  // This includes the all-minimum-value operand case.
  function automatic int prod_width(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

endpackage

// File: rtl/cmult_stream_if.sv
// Stream bundle for cmult_stream: the input sample side and the output product side.
// Latency: n/a (interface). Backpressure: in_ready / out_ready valid-ready handshakes.
// Modports: slave = the multiplier, master = whatever feeds and drains it.
interface cmult_stream_if #(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18,
  parameter int OWIDTH = 16,
  parameter int UWIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [AWIDTH-1:0] ar;
  logic signed [AWIDTH-1:0] ai;
  logic signed [BWIDTH-1:0] br;
  logic signed [BWIDTH-1:0] bi;
  logic                     conj_b;
  logic [UWIDTH-1:0]        in_user;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [OWIDTH-1:0] pr;
  logic signed [OWIDTH-1:0] pi;
  logic                     ovf;
  logic [UWIDTH-1:0]        out_user;

  modport slave (
    input  in_valid, ar, ai, br, bi, conj_b, in_user, out_ready,
    output in_ready, out_valid, pr, pi, ovf, out_user
  );

  modport master (
    output in_valid, ar, ai, br, bi, conj_b, in_user, out_ready,
    input  in_ready, out_valid, pr, pi, ovf, out_user
  );
endinterface

// File: rtl/cmult_stream_round_sat.sv
// Rounds (half toward +inf), arithmetic-shifts and saturates one complex sample.
// Latency: 1 register stage. Backpressure: the stage holds while ce is low.
// Ports: clk, rst_n, ce, in_vld, re/im (IWIDTH) in; out_vld, pr/pi (OWIDTH), ovf out.
module round_sat
  import cmult_pkg::*;
#(
  parameter int IWIDTH = 35,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 17
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     in_vld,
  input  logic signed [IWIDTH-1:0] re,
  input  logic signed [IWIDTH-1:0] im,
  output logic                     out_vld,
  output logic signed [OWIDTH-1:0] pr,
  output logic signed [OWIDTH-1:0] pi,
  output logic                     ovf
);
  // One guard bit absorbs the rounding carry.
  // Widen further if the output is wider than the input so the limit compares stay exact.
  localparam int CW  = (IWIDTH + 1 > OWIDTH + 1) ? IWIDTH + 1 : OWIDTH + 1;
  localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [CW-1:0] RND  = (SHIFT > 0) ? (CW'(1) << SH1) : '0;
  localparam logic signed [CW-1:0] OMAX = {{(CW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN = {{(CW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  function automatic logic signed [CW-1:0] scale(input logic signed [IWIDTH-1:0] v);
    logic signed [CW-1:0] x;
    x = CW'(v) + RND;
    return x >>> SHIFT;
  endfunction

  function automatic logic sat(input logic signed [CW-1:0] x);
    return (x > OMAX) || (x < OMIN);
  endfunction

  function automatic logic signed [OWIDTH-1:0] clamp(input logic signed [CW-1:0] x);
    if (x > OMAX)      return {1'b0, {(OWIDTH-1){1'b1}}};
    else if (x < OMIN) return {1'b1, {(OWIDTH-1){1'b0}}};
    else               return x[OWIDTH-1:0];
  endfunction

  logic signed [CW-1:0] sr;
  logic signed [CW-1:0] si;
  assign sr = scale(re);
  assign si = scale(im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      pr      <= '0;
      pi      <= '0;
      ovf     <= 1'b0;
    end else if (ce) begin
      out_vld <= in_vld;
      pr      <= clamp(sr);
      pi      <= clamp(si);
      // Bubbles never report saturation.
      ovf     <= in_vld && (sat(sr) || sat(si));
    end
  end
endmodule

// File: rtl/cmult_stream.sv
// Streaming complex multiplier: P = A*B or A*conj(B), 3 multipliers, rounded and saturated.
// Latency: CMULT_LAT (6) advancing cycles, 1 sample/cycle. Backpressure: one global ce.
// Ports: clk, rst_n (async, active-low), bus (cmult_stream_if.slave: in/out streams).
module cmult_stream
  import cmult_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18,
  parameter int OWIDTH = 16,
  parameter int SHIFT  = 17,
  parameter int UWIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  cmult_stream_if.slave bus
);
  localparam int PW = prod_width(AWIDTH, BWIDTH);  // exact result width
  localparam int MW = PW + 1;                      // a * (b sum) product width
  localparam int VW = CMULT_LAT - 1;               // stages ahead of round_sat

  // The pipeline only stalls when a valid output is not being taken.
  // Every stage, bubble or not, moves together.
  logic ce;
  assign ce           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ce;

  logic [VW-1:0]     vld;
  logic [UWIDTH-1:0] usr [VW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else if (ce) vld <= {vld[VW-2:0], bus.in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.out_user <= '0;
    else if (ce) bus.out_user <= usr[VW-1];
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      usr[0] <= bus.in_user;
      for (int i = 1; i < VW; i++) usr[i] <= usr[i-1];
    end
  end

  // Stage 1: operand capture.
  logic signed [AWIDTH-1:0] a1r, a1i;
  logic signed [BWIDTH-1:0] b1r, b1i;
  logic                     c1;
  // Stage 2: pre-adders.
  logic signed [AWIDTH:0]   sa2;
  logic signed [BWIDTH+1:0] dsum2, ddif2;
  logic signed [AWIDTH-1:0] a2r, a2i;
  logic signed [BWIDTH-1:0] b2r;
  // Stage 3/4: products, registered twice.
  logic signed [PW-1:0]     m1_3, m1_4;
  logic signed [MW-1:0]     m2_3, m3_3, m2_4, m3_4;
  // Stage 5: post-adders.
  logic signed [PW-1:0]     pr5, pi5;

  // Conjugation flips the sign of the imaginary part of B.
  // One extra bit keeps -min exact.
  logic signed [BWIDTH:0] bq;
  assign bq = c1 ? -((BWIDTH+1)'(b1i)) : (BWIDTH+1)'(b1i);

  // Three-multiplier form with a shared common term m1 = br*(ar+ai):
  //   re = m1 - ai*(br+bq)
  //   im = m1 + ar*(bq-br)
  // Intermediate sums may wrap modulo 2^MW.
  // The true results fit in PW bits, so the low PW bits are exact.
  always_ff @(posedge clk) begin
    if (ce) begin
      a1r   <= bus.ar;
      a1i   <= bus.ai;
      b1r   <= bus.br;
      b1i   <= bus.bi;
      c1    <= bus.conj_b;

      sa2   <= (AWIDTH+1)'(a1r) + (AWIDTH+1)'(a1i);
      dsum2 <= (BWIDTH+2)'(b1r) + (BWIDTH+2)'(bq);
      ddif2 <= (BWIDTH+2)'(bq) - (BWIDTH+2)'(b1r);
      a2r   <= a1r;
      a2i   <= a1i;
      b2r   <= b1r;

      m1_3  <= PW'(sa2) * PW'(b2r);
      m2_3  <= MW'(a2r) * MW'(ddif2);
      m3_3  <= MW'(a2i) * MW'(dsum2);

      m1_4  <= m1_3;
      m2_4  <= m2_3;
      m3_4  <= m3_3;

      pr5   <= PW'(MW'(m1_4) - m3_4);
      pi5   <= PW'(MW'(m1_4) + m2_4);
    end
  end

  // Stage 6: round, shift, saturate (output registers).
  round_sat #(
    .IWIDTH (PW),
    .OWIDTH (OWIDTH),
    .SHIFT  (SHIFT)
  ) u_round_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .in_vld  (vld[VW-1]),
    .re      (pr5),
    .im      (pi5),
    .out_vld (bus.out_valid),
    .pr      (bus.pr),
    .pi      (bus.pi),
    .ovf     (bus.ovf)
  );
endmodule

// File: tb/tb_cmult_stream.sv
// Bench for cmult_stream: two instances (16-bit/shift 17 and exact 35-bit/shift 0) fed alike.
// A queue-based model predicts every output cycle from products, rounding rules and a 6-advance latency.
// Directed cases, stall window, reset-in-flight and a random backpressured stream.
module tb_cmult_stream;
  localparam int LAT = 6;

  typedef logic signed [63:0] v64;
  typedef struct {
    longint pr0, pi0, pr1, pi1;
    bit ovf0, ovf1;
    logic [7:0] user;
    int stamp;
  } exp_t;

  logic clk;
  logic rst_n;
  logic in_valid, out_ready, conj_b;
  logic signed [15:0] ar, ai;
  logic signed [17:0] br, bi;
  logic [7:0] in_user;

  int checks = 0;
  int errors = 0;
  int nacc = 0;
  int nout = 0;
  int adv_cnt = 0;
  exp_t q[$];

  cmult_stream_if #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(16), .UWIDTH(8)) i0 ();
  cmult_stream_if #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(35), .UWIDTH(8)) i1 ();

  assign i0.in_valid = in_valid;  assign i1.in_valid = in_valid;
  assign i0.ar = ar;              assign i1.ar = ar;
  assign i0.ai = ai;              assign i1.ai = ai;
  assign i0.br = br;              assign i1.br = br;
  assign i0.bi = bi;              assign i1.bi = bi;
  assign i0.conj_b = conj_b;      assign i1.conj_b = conj_b;
  assign i0.in_user = in_user;    assign i1.in_user = in_user;
  assign i0.out_ready = out_ready; assign i1.out_ready = out_ready;

  cmult_stream #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(16), .SHIFT(17), .UWIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(i0));
  cmult_stream #(.AWIDTH(16), .BWIDTH(18), .OWIDTH(35), .SHIFT(0), .UWIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(i1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input v64 act, input v64 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic longint full_re(input longint xr, xi, yr, yi, input bit c);
    return c ? xr * yr + xi * yi : xr * yr - xi * yi;
  endfunction

  function automatic longint full_im(input longint xr, xi, yr, yi, input bit c);
    return c ? xi * yr - xr * yi : xr * yi + xi * yr;
  endfunction

  function automatic longint rnd_shift(input longint v, input int sh);
    if (sh == 0) return v;
    return (v + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic bit is_sat(input longint v, input int ow);
    longint mx;
    mx = (longint'(1) << (ow - 1)) - 1;
    return (v > mx) || (v < -mx - 1);
  endfunction

  function automatic longint clampv(input longint v, input int ow);
    longint mx;
    mx = (longint'(1) << (ow - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  // ---------------- cycle-level model and compare ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    bit ev, ce;
    longint fr, fi;
    if (!rst_n) begin
      nacc = nacc - q.size();
      q.delete();
    end else begin
      ev = (q.size() != 0) && ((adv_cnt - q[0].stamp) == LAT);
      chk("out_valid0", i0.out_valid, ev);
      chk("out_valid1", i1.out_valid, ev);
      if (ev) begin
        chk("pr0", i0.pr, q[0].pr0);
        chk("pi0", i0.pi, q[0].pi0);
        chk("ovf0", i0.ovf, q[0].ovf0);
        chk("user0", i0.out_user, q[0].user);
        chk("pr1", i1.pr, q[0].pr1);
        chk("pi1", i1.pi, q[0].pi1);
        chk("ovf1", i1.ovf, q[0].ovf1);
        chk("user1", i1.out_user, q[0].user);
      end else begin
        chk("ovf_idle0", i0.ovf, 0);
        chk("ovf_idle1", i1.ovf, 0);
      end
      ce = !ev || out_ready;
      chk("in_ready0", i0.in_ready, ce);
      chk("in_ready1", i1.in_ready, ce);
      if (ev && out_ready) nout++;
      if (in_valid && ce) begin
        fr = full_re(ar, ai, br, bi, conj_b);
        fi = full_im(ar, ai, br, bi, conj_b);
        e.pr0  = clampv(rnd_shift(fr, 17), 16);
        e.pi0  = clampv(rnd_shift(fi, 17), 16);
        e.ovf0 = is_sat(rnd_shift(fr, 17), 16) || is_sat(rnd_shift(fi, 17), 16);
        e.pr1  = clampv(rnd_shift(fr, 0), 35);
        e.pi1  = clampv(rnd_shift(fi, 0), 35);
        e.ovf1 = is_sat(fr, 35) || is_sat(fi, 35);
        e.user = in_user;
        e.stamp = adv_cnt;
        q.push_back(e);
        nacc++;
      end
      if (ce) begin
        if (ev) void'(q.pop_front());
        adv_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic signed [15:0] rnd_a();
    logic signed [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'sh8000;
      1: v = 16'sh7fff;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic signed [17:0] rnd_b();
    logic signed [17:0] v;
    case ($urandom_range(0, 7))
      0: v = 18'sh20000;
      1: v = 18'sh1ffff;
      default: v = 18'($urandom);
    endcase
    return v;
  endfunction

  task automatic drive_rand();
    ar = rnd_a(); ai = rnd_a(); br = rnd_b(); bi = rnd_b();
    conj_b = 1'($urandom); in_user = 8'($urandom);
  endtask

  // Called just after a rising edge; presents one sample for one cycle (out_ready high).
  task automatic send(input logic signed [15:0] xr, xi, input logic signed [17:0] yr, yi,
                      input logic c, input logic [7:0] u);
    ar = xr; ai = xi; br = yr; bi = yi; conj_b = c; in_user = u; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic measure(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i0.out_valid && n < 20);
    chk(nm, n, LAT);
  endtask

  // mode 0: valid every cycle, out_ready low in cycles 8..10; mode 1: random bubbles and stalls.
  task automatic stream(input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    bit pending = 0;
    while (acc < n && cyc < 4000) begin
      @(posedge clk); #1;
      if (mode == 0) begin
        out_ready = !(cyc >= 8 && cyc <= 10);
        in_valid = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      if (!pending) begin
        drive_rand();
        pending = 1;
      end
      #2;
      if (in_valid && i0.in_ready) begin
        acc++;
        pending = 0;
      end
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stream_accepted", acc, n);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ar = '0; ai = '0; br = '0; bi = '0; conj_b = 1'b0; in_user = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_ovf", i0.ovf, 0);
    chk("rst_pr", i0.pr, 0);
    chk("rst_pi", i0.pi, 0);
    chk("rst_user", i0.out_user, 0);
    chk("rst_in_ready", i0.in_ready, 1);
    chk("rst_out_valid1", i1.out_valid, 0);
    rst_n = 1'b1;

    // Hand-computed values that pin the model arithmetic.
    chk("pin_034_pr", clampv(rnd_shift(full_re(16384, 0, 65536, 0, 0), 17), 16), 8192);
    chk("pin_035_re0", full_re(1000, 2000, 3000, 4000, 0), -5000000);
    chk("pin_035_im0", full_im(1000, 2000, 3000, 4000, 0), 10000000);
    chk("pin_035_re1", full_re(1000, 2000, 3000, 4000, 1), 11000000);
    chk("pin_035_im1", full_im(1000, 2000, 3000, 4000, 1), 2000000);
    chk("pin_036_pr", clampv(rnd_shift(full_re(-32768, -32768, -131072, 131071, 0), 17), 16), 32767);
    chk("pin_036_pi", clampv(rnd_shift(full_im(-32768, -32768, -131072, 131071, 0), 17), 16), 0);
    chk("pin_036_sat", is_sat(rnd_shift(full_re(-32768, -32768, -131072, 131071, 0), 17), 16), 1);
    chk("pin_round_pos", rnd_shift(3, 1), 2);
    chk("pin_round_neg", rnd_shift(-3, 1), -1);

    // Single sample: latency and literal output values.
    @(posedge clk); #1;
    send(16'sd16384, 16'sd0, 18'sd65536, 18'sd0, 1'b0, 8'h5a);
    in_valid = 1'b0;
    measure("lat_first");
    chk("d034_pr", i0.pr, 8192);
    chk("d034_pi", i0.pi, 0);
    chk("d034_ovf", i0.ovf, 0);
    chk("d034_user", i0.out_user, 8'h5a);
    repeat (8) @(posedge clk);

    // Back-to-back normal/conjugate pair, then the all-minimum saturation case.
    #1;
    send(16'sd1000, 16'sd2000, 18'sd3000, 18'sd4000, 1'b0, 8'h01);
    send(16'sd1000, 16'sd2000, 18'sd3000, 18'sd4000, 1'b1, 8'h02);
    send(16'sh8000, 16'sh8000, 18'sh20000, 18'sh1ffff, 1'b0, 8'h03);
    in_valid = 1'b0;
    drain();

    // 20 samples with a three-cycle output stall.
    stream(20, 0);
    drain();

    // Reset with samples in flight and one on the output.
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (7) begin
      drive_rand();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    chk("rst_pre_ovld", i0.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ovld0", i0.out_valid, 0);
    chk("rst_async_ovld1", i1.out_valid, 0);
    chk("rst_async_ovf", i0.ovf, 0);
    chk("rst_async_in_ready", i0.in_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    drive_rand();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    measure("lat_after_rst");
    drain();

    // Long random stream with bubbles and random backpressure.
    stream(200, 1);
    drain();
    chk("out_count", nout, nacc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
